// File: rtl/vxe_vpu_prod_eu_rqctl.sv
//==============================================================================
// Module   : vxe_vpu_prod_eu_rqctl
// Brief    : Two-vector fetch request controller; VXE_VPU_RQCTL_RR_EN selects
//            round-robin arbitration (default fixed priority, vector 0 wins).
// Revision : 1.0
//==============================================================================
`default_nettype none

module vxe_vpu_prod_eu_rqctl #(
    parameter int MAX_OUT = 8
) (
    input  logic        clk,
    input  logic        nrst,

    input  logic        i_start,
    input  logic [37:0] i_vaddr0,
    input  logic [37:0] i_vaddr1,
    input  logic [19:0] i_vlen0,
    input  logic [19:0] i_vlen1,
    output logic        o_busy,
    output logic        o_done,

    output logic [37:0] o_ag0_vaddr,
    output logic [19:0] o_ag0_vlen,
    output logic [37:0] o_ag1_vaddr,
    output logic [19:0] o_ag1_vlen,
    output logic        o_ag0_latch,
    output logic        o_ag0_incr,
    output logic        o_ag1_latch,
    output logic        o_ag1_incr,

    input  logic        i_ag0_valid,
    input  logic [36:0] i_ag0_addr,
    input  logic [1:0]  i_ag0_we_mask,
    input  logic        i_ag1_valid,
    input  logic [36:0] i_ag1_addr,
    input  logic [1:0]  i_ag1_we_mask,

    output logic        o_rqa_vld,
    input  logic        i_rqa_rdy,
    output logic [36:0] o_rqa_addr,
    output logic [1:0]  o_rqa_mask,
    output logic        o_rqa_tag,

    input  logic        i_rss_vld
);

    localparam logic [3:0] C_MAX_OUT = 4'(MAX_OUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_lock;
    logic       r_lock_gnt;

    logic       w_gnt;
    logic       w_any_valid;
    logic       w_rqa_vld;
    logic       w_xfer;
    logic       w_dec;

    assign w_any_valid = i_ag0_valid | i_ag1_valid;

`ifdef VXE_VPU_RQCTL_RR_EN
    // Pointer names the vector that wins the next contended cycle.
    logic r_rr_ptr;

    always_comb begin
        w_gnt = ~i_ag0_valid;
        if (r_lock) begin
            w_gnt = r_lock_gnt;
        end else if (i_ag0_valid && i_ag1_valid) begin
            w_gnt = r_rr_ptr;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_xfer) begin
            r_rr_ptr <= ~w_gnt;
        end
    end
`else
    always_comb begin
        w_gnt = ~i_ag0_valid;
        if (r_lock) begin
            w_gnt = r_lock_gnt;
        end
    end
`endif

    // A stalled request keeps its grant, so fields hold until the handshake.
    assign w_rqa_vld = (r_state == ST_RUN) &
                       (r_lock | ((r_cnt < C_MAX_OUT) & w_any_valid));
    assign w_xfer    = w_rqa_vld & i_rqa_rdy;
    assign w_dec     = i_rss_vld & (r_cnt != 4'd0);

    assign o_rqa_vld  = w_rqa_vld;
    assign o_rqa_addr = w_gnt ? i_ag1_addr    : i_ag0_addr;
    assign o_rqa_mask = w_gnt ? i_ag1_we_mask : i_ag0_we_mask;
    assign o_rqa_tag  = w_gnt;

    assign o_ag0_incr  = w_xfer & ~w_gnt;
    assign o_ag1_incr  = w_xfer &  w_gnt;
    assign o_ag0_latch = (r_state == ST_LATCH);
    assign o_ag1_latch = (r_state == ST_LATCH);

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_DRAIN) && (r_cnt == 4'd0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            o_ag0_vaddr <= '0;
            o_ag0_vlen  <= '0;
            o_ag1_vaddr <= '0;
            o_ag1_vlen  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_ag0_vaddr <= i_vaddr0;
                        o_ag0_vlen  <= i_vlen0;
                        o_ag1_vaddr <= i_vaddr1;
                        o_ag1_vlen  <= i_vlen1;
                        r_state     <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!w_any_valid && !r_lock) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Responses with nothing outstanding are dropped to prevent underflow.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt      <= 4'd0;
            r_lock     <= 1'b0;
            r_lock_gnt <= 1'b0;
        end else begin
            r_cnt      <= r_cnt + {3'd0, w_xfer} - {3'd0, w_dec};
            r_lock     <= w_rqa_vld & ~i_rqa_rdy;
            r_lock_gnt <= w_gnt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vxe_vpu_prod_eu_rqctl.sv
//==============================================================================
// Module   : tb_vxe_vpu_prod_eu_rqctl
// Brief    : Self-checking bench with a word-level address generator and a
//            cycle reference model of the request controller.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_vxe_vpu_prod_eu_rqctl;

    localparam int MAX_OUT  = 3;
`ifdef VXE_VPU_RQCTL_RR_EN
    localparam bit RR_EN    = 1'b1;
`else
    localparam bit RR_EN    = 1'b0;
`endif
    localparam int PH_IDLE  = 0;
    localparam int PH_LATCH = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DRAIN = 3;

    logic        clk;
    logic        nrst;
    logic        i_start;
    logic [37:0] i_vaddr0, i_vaddr1;
    logic [19:0] i_vlen0, i_vlen1;
    logic        o_busy, o_done;
    logic [37:0] o_ag0_vaddr, o_ag1_vaddr;
    logic [19:0] o_ag0_vlen, o_ag1_vlen;
    logic        o_ag0_latch, o_ag0_incr, o_ag1_latch, o_ag1_incr;
    logic        i_ag0_valid, i_ag1_valid;
    logic [36:0] i_ag0_addr, i_ag1_addr;
    logic [1:0]  i_ag0_we_mask, i_ag1_we_mask;
    logic        o_rqa_vld, i_rqa_rdy;
    logic [36:0] o_rqa_addr;
    logic [1:0]  o_rqa_mask;
    logic        o_rqa_tag;
    logic        i_rss_vld;

    vxe_vpu_prod_eu_rqctl #(.MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .nrst(nrst),
        .i_start(i_start), .i_vaddr0(i_vaddr0), .i_vaddr1(i_vaddr1),
        .i_vlen0(i_vlen0), .i_vlen1(i_vlen1),
        .o_busy(o_busy), .o_done(o_done),
        .o_ag0_vaddr(o_ag0_vaddr), .o_ag0_vlen(o_ag0_vlen),
        .o_ag1_vaddr(o_ag1_vaddr), .o_ag1_vlen(o_ag1_vlen),
        .o_ag0_latch(o_ag0_latch), .o_ag0_incr(o_ag0_incr),
        .o_ag1_latch(o_ag1_latch), .o_ag1_incr(o_ag1_incr),
        .i_ag0_valid(i_ag0_valid), .i_ag0_addr(i_ag0_addr), .i_ag0_we_mask(i_ag0_we_mask),
        .i_ag1_valid(i_ag1_valid), .i_ag1_addr(i_ag1_addr), .i_ag1_we_mask(i_ag1_we_mask),
        .o_rqa_vld(o_rqa_vld), .i_rqa_rdy(i_rqa_rdy),
        .o_rqa_addr(o_rqa_addr), .o_rqa_mask(o_rqa_mask), .o_rqa_tag(o_rqa_tag),
        .i_rss_vld(i_rss_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Address generator environment: walks words, emits double-word requests.
    logic [37:0] ag_w[2];
    int          ag_rem[2];
    logic        cap_latch[2];
    logic        cap_incr[2];

    function automatic logic [1:0] ag_mask(input logic [37:0] w, input int rem);
        if (rem == 0)      return 2'b00;
        else if (w[0])     return 2'b10;
        else if (rem >= 2) return 2'b11;
        else               return 2'b01;
    endfunction

    task automatic drive_ag();
        logic [37:0] w0, w1;
        w0 = ag_w[0];
        w1 = ag_w[1];
        i_ag0_valid   = (ag_rem[0] > 0);
        i_ag0_addr    = w0[37:1];
        i_ag0_we_mask = ag_mask(w0, ag_rem[0]);
        i_ag1_valid   = (ag_rem[1] > 0);
        i_ag1_addr    = w1[37:1];
        i_ag1_we_mask = ag_mask(w1, ag_rem[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (cap_latch[n]) begin
                ag_w[n]   = (n == 1) ? o_ag1_vaddr : o_ag0_vaddr;
                ag_rem[n] = int'((n == 1) ? o_ag1_vlen : o_ag0_vlen);
            end else if (cap_incr[n] && ag_rem[n] > 0) begin
                int step;
                step = (ag_w[n][0] || ag_rem[n] == 1) ? 1 : 2;
                ag_w[n]   = ag_w[n] + 38'(step);
                ag_rem[n] = ag_rem[n] - step;
            end
        end
        drive_ag();
    endtask

    // Reference model state
    int          m_ph = PH_IDLE;
    int          m_out = 0;
    bit          m_hold = 1'b0;
    int          m_hold_tag = 0;
    int          m_last = 1;          // last vector served; 1 means vector 0 is favoured
    logic [37:0] m_va0 = '0, m_va1 = '0;
    logic [19:0] m_vl0 = '0, m_vl1 = '0;

    typedef struct {
        logic [36:0] a;
        logic [1:0]  m;
        logic        t;
    } req_t;
    req_t log_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   xfer_cnt = 0;
    int   incr_cnt = 0;

    always @(negedge clk) begin : mon
        logic v0, v1, e_vld, e_xfer;
        int   e_tag;
        v0 = i_ag0_valid;
        v1 = i_ag1_valid;
        if (!nrst) begin
            chk("rst_busy",  64'(o_busy), 64'(0));
            chk("rst_done",  64'(o_done), 64'(0));
            chk("rst_vld",   64'(o_rqa_vld), 64'(0));
            chk("rst_latch", 64'({o_ag0_latch, o_ag1_latch}), 64'(0));
            chk("rst_incr",  64'({o_ag0_incr, o_ag1_incr}), 64'(0));
            chk("rst_agregs", 64'(o_ag0_vaddr | o_ag1_vaddr), 64'(0));
            chk("rst_aglen", 64'(o_ag0_vlen | o_ag1_vlen), 64'(0));
            m_ph = PH_IDLE; m_out = 0; m_hold = 1'b0; m_last = 1;
            m_va0 = '0; m_va1 = '0; m_vl0 = '0; m_vl1 = '0;
        end else begin
            if (m_hold)              e_tag = m_hold_tag;
            else if (v0 && v1)       e_tag = (RR_EN && m_last == 0) ? 1 : 0;
            else                     e_tag = v0 ? 0 : 1;
            e_vld  = (m_ph == PH_RUN) && (m_hold || (m_out < MAX_OUT && (v0 || v1)));
            e_xfer = e_vld && i_rqa_rdy;

            chk("busy",    64'(o_busy), 64'(m_ph != PH_IDLE));
            chk("done",    64'(o_done), 64'(m_ph == PH_DRAIN && m_out == 0));
            chk("latch0",  64'(o_ag0_latch), 64'(m_ph == PH_LATCH));
            chk("latch1",  64'(o_ag1_latch), 64'(m_ph == PH_LATCH));
            chk("rqa_vld", 64'(o_rqa_vld), 64'(e_vld));
            chk("incr0",   64'(o_ag0_incr), 64'(e_xfer && e_tag == 0));
            chk("incr1",   64'(o_ag1_incr), 64'(e_xfer && e_tag == 1));
            if (e_vld) begin
                chk("rqa_addr", 64'(o_rqa_addr), 64'(e_tag == 1 ? i_ag1_addr : i_ag0_addr));
                chk("rqa_mask", 64'(o_rqa_mask), 64'(e_tag == 1 ? i_ag1_we_mask : i_ag0_we_mask));
                chk("rqa_tag",  64'(o_rqa_tag), 64'(e_tag));
            end
            chk("ag0_vaddr", 64'(o_ag0_vaddr), 64'(m_va0));
            chk("ag1_vaddr", 64'(o_ag1_vaddr), 64'(m_va1));
            chk("ag0_vlen",  64'(o_ag0_vlen), 64'(m_vl0));
            chk("ag1_vlen",  64'(o_ag1_vlen), 64'(m_vl1));

            case (m_ph)
                PH_IDLE:  if (i_start) begin
                              m_va0 = i_vaddr0; m_va1 = i_vaddr1;
                              m_vl0 = i_vlen0;  m_vl1 = i_vlen1;
                              m_ph  = PH_LATCH;
                          end
                PH_LATCH: m_ph = PH_RUN;
                PH_RUN:   if (!v0 && !v1 && !m_hold) m_ph = PH_DRAIN;
                default:  if (m_out == 0) m_ph = PH_IDLE;
            endcase
            m_out      = m_out + (e_xfer ? 1 : 0) - ((i_rss_vld && m_out > 0) ? 1 : 0);
            m_hold     = e_vld && !i_rqa_rdy;
            m_hold_tag = e_tag;
            if (e_xfer) m_last = e_tag;
        end
        if (o_rqa_vld && i_rqa_rdy) begin
            log_q.push_back('{a: o_rqa_addr, m: o_rqa_mask, t: o_rqa_tag});
            xfer_cnt++;
        end
        if (o_ag0_incr || o_ag1_incr) incr_cnt++;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cap_latch[0] = o_ag0_latch;
        cap_latch[1] = o_ag1_latch;
        cap_incr[0]  = o_ag0_incr;
        cap_incr[1]  = o_ag1_incr;
    end

    int st_cyc = 0;

    task automatic start_fetch(input logic [37:0] a0, input int l0,
                               input logic [37:0] a1, input int l1);
        int k;
        k = 0;
        while (o_busy && k < 500) begin
            tick();
            k++;
        end
        i_vaddr0 = a0; i_vlen0 = 20'(l0);
        i_vaddr1 = a1; i_vlen1 = 20'(l1);
        i_start  = 1'b1;
        st_cyc   = cyc;
        tick();
        i_start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int d0, k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (done_cnt == d0) begin
            n_err++;
            $display("FAIL %s: no done within %0d cycles", nm, budget);
        end
    endtask

    task automatic chk_req(input int i, input logic [36:0] a, input logic [1:0] m, input logic t);
        if (i < log_q.size()) begin
            chk("req_addr", 64'(log_q[i].a), 64'(a));
            chk("req_mask", 64'(log_q[i].m), 64'(m));
            chk("req_tag",  64'(log_q[i].t), 64'(t));
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL req_missing: request %0d absent, log holds %0d", i, log_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, i0, d0;
        nrst = 1'b0; i_start = 1'b0;
        i_vaddr0 = '0; i_vaddr1 = '0; i_vlen0 = '0; i_vlen1 = '0;
        i_rqa_rdy = 1'b0; i_rss_vld = 1'b0;
        for (int n = 0; n < 2; n++) begin
            ag_w[n] = '0; ag_rem[n] = 0; cap_latch[n] = 1'b0; cap_incr[n] = 1'b0;
        end
        drive_ag();
        repeat (3) tick();
        nrst = 1'b1;
        tick();

        // Two contending length-4 vectors straight after reset
        log_q.delete();
        i_rqa_rdy = 1'b1; i_rss_vld = 1'b1;
        start_fetch(38'h0, 4, 38'h100, 4);
        wait_done(100, "arb_done");
        chk("arb_nreq", 64'(log_q.size()), 64'(4));
        if (RR_EN) begin
            chk_req(0, 37'h00, 2'b11, 1'b0);
            chk_req(1, 37'h80, 2'b11, 1'b1);
            chk_req(2, 37'h01, 2'b11, 1'b0);
            chk_req(3, 37'h81, 2'b11, 1'b1);
        end else begin
            chk_req(0, 37'h00, 2'b11, 1'b0);
            chk_req(1, 37'h01, 2'b11, 1'b0);
            chk_req(2, 37'h80, 2'b11, 1'b1);
            chk_req(3, 37'h81, 2'b11, 1'b1);
        end

        // Back-pressure: request must hold while ready is low
        log_q.delete();
        i_rqa_rdy = 1'b0; i_rss_vld = 1'b0;
        start_fetch(38'h11, 6, 38'h40, 4);
        tick();
        i0 = incr_cnt;
        repeat (5) tick();
        chk("stall_vld",  64'(o_rqa_vld), 64'(1));
        chk("stall_addr", 64'(o_rqa_addr), 64'(37'h08));
        chk("stall_mask", 64'(o_rqa_mask), 64'(2'b10));
        chk("stall_tag",  64'(o_rqa_tag), 64'(0));
        chk("stall_incr", 64'(incr_cnt - i0), 64'(0));
        chk("stall_nreq", 64'(log_q.size()), 64'(0));
        i_rqa_rdy = 1'b1; i_rss_vld = 1'b1;
        wait_done(100, "stall_done");
        chk("stall_total", 64'(log_q.size()), 64'(6));

        // Single aligned vector
        log_q.delete();
        start_fetch(38'h10, 4, 38'h0, 0);
        wait_done(100, "v0_done");
        chk("v0_nreq", 64'(log_q.size()), 64'(2));
        chk_req(0, 37'h08, 2'b11, 1'b0);
        chk_req(1, 37'h09, 2'b11, 1'b0);

        // Misaligned start splits into partial masks
        log_q.delete();
        start_fetch(38'h11, 2, 38'h0, 0);
        wait_done(100, "mis_done");
        chk("mis_nreq", 64'(log_q.size()), 64'(2));
        chk_req(0, 37'h08, 2'b10, 1'b0);
        chk_req(1, 37'h09, 2'b01, 1'b0);

        // Empty fetch: done three cycles after start, exactly one pulse
        d0 = done_cnt;
        start_fetch(38'h5, 0, 38'h7, 0);
        wait_done(20, "empty_done");
        chk("empty_lat", 64'(done_cyc - st_cyc), 64'(3));
        repeat (4) tick();
        chk("empty_pulses", 64'(done_cnt - d0), 64'(1));

        // Outstanding limit
        i_rqa_rdy = 1'b1; i_rss_vld = 1'b0;
        x0 = xfer_cnt;
        start_fetch(38'h0, 16, 38'h0, 0);
        repeat (20) tick();
        chk("sat_xfers", 64'(xfer_cnt - x0), 64'(MAX_OUT));
        chk("sat_vld",   64'(o_rqa_vld), 64'(0));
        chk("sat_busy",  64'(o_busy), 64'(1));
        i_rss_vld = 1'b1;
        tick();
        i_rss_vld = 1'b0;
        repeat (10) tick();
        chk("sat_xfers2", 64'(xfer_cnt - x0), 64'(MAX_OUT + 1));
        i_rss_vld = 1'b1;
        wait_done(200, "sat_done");

        // Reset while saturated abandons outstanding requests
        i_rss_vld = 1'b0;
        x0 = xfer_cnt;
        start_fetch(38'h0, 16, 38'h0, 0);
        repeat (10) tick();
        chk("rst_pre_xfers", 64'(xfer_cnt - x0), 64'(3));
        nrst = 1'b0;
        #2;
        chk("rst_now_busy", 64'(o_busy), 64'(0));
        chk("rst_now_vld",  64'(o_rqa_vld), 64'(0));
        tick();
        nrst = 1'b1;
        d0 = done_cnt;
        repeat (3) tick();
        chk("rst_no_done", 64'(done_cnt - d0), 64'(0));
        x0 = xfer_cnt;
        start_fetch(38'h0, 16, 38'h0, 0);
        repeat (10) tick();
        chk("rst_cnt_clear", 64'(xfer_cnt - x0), 64'(MAX_OUT));
        i_rss_vld = 1'b1;
        wait_done(200, "rst_done");

        // Randomized fetches with spurious starts, random ready and responses
        for (int it = 0; it < 40; it++) begin
            int l0, l1, k;
            l0 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 9));
            l1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 9));
            i_rqa_rdy = 1'($urandom_range(0, 1));
            i_rss_vld = 1'($urandom_range(0, 1));
            start_fetch(38'($urandom_range(0, 255)), l0, 38'($urandom_range(0, 255)), l1);
            d0 = done_cnt;
            k  = 0;
            while (done_cnt == d0 && k < 400) begin
                i_rqa_rdy = ($urandom_range(0, 3) != 0);
                i_rss_vld = ($urandom_range(0, 2) != 0);
                i_start   = ($urandom_range(0, 7) == 0);
                i_vaddr0  = 38'($urandom);
                i_vaddr1  = 38'($urandom);
                i_vlen0   = 20'($urandom_range(0, 15));
                i_vlen1   = 20'($urandom_range(0, 15));
                tick();
                k++;
            end
            i_start = 1'b0;
            n_cmp++;
            if (done_cnt == d0) begin
                n_err++;
                $display("FAIL rand_done: iteration %0d no done within 400 cycles", it);
            end
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
